// File: rtl/square_arbiter.sv
// Round-robin arbiter sharing one square unit between N_REQ requesters.
// Optional WAIT watchdog is built when SQUARE_ARB_TIMEOUT_EN is defined.
module square_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ID_W           = $clog2(N_REQ),
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [N_REQ-1:0]     req_in,
  input  logic [8*N_REQ-1:0]   value_in,
  output logic [N_REQ-1:0]     grant_out,
  output logic [15:0]          result_out,
  output logic [ID_W-1:0]      result_id_out,
  output logic                 result_valid_out,
  output logic                 busy_out,
  output logic                 error_out,
  output logic                 sq_ready_out,
  output logic [7:0]           sq_value_out,
  input  logic [15:0]          sq_square_in,
  input  logic                 sq_busy_in,
  input  logic                 sq_valid_in
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] win_next;
  logic            found;
  logic [7:0]      ops [N_REQ];

  // The square unit's busy flag is informational only.
  logic unused_busy;
  assign unused_busy = sq_busy_in;

  for (genvar i = 0; i < N_REQ; i++) begin : g_ops
    assign ops[i] = value_in[8*i +: 8];
  end

  // First set request at or above rr_ptr, wrapping past N_REQ-1.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_in[ID_W'(idx)]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  assign win_next = (win == ID_W'(N_REQ-1)) ? '0 : win + 1'b1;
  assign busy_out = (state != IDLE);

`ifdef SQUARE_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign error_out = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      grant_out        <= '0;
      sq_ready_out     <= 1'b0;
      sq_value_out     <= '0;
      result_out       <= '0;
      result_id_out    <= '0;
      result_valid_out <= 1'b0;
`ifdef SQUARE_ARB_TIMEOUT_EN
      error_out        <= 1'b0;
      wait_cnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_out     <= N_REQ'(1) << win;
            sq_ready_out  <= 1'b1;
            sq_value_out  <= ops[win];
            result_id_out <= win;
            rr_ptr        <= win_next;
            state         <= LAUNCH;
          end
        end
        LAUNCH: begin
          grant_out    <= '0;
          sq_ready_out <= 1'b0;
`ifdef SQUARE_ARB_TIMEOUT_EN
          wait_cnt     <= '0;
`endif
          state        <= WAIT;
        end
        WAIT: begin
          // A valid on the final watchdog cycle still counts as a result.
          if (sq_valid_in) begin
            result_out       <= sq_square_in;
            result_valid_out <= 1'b1;
            state            <= DONE;
          end
`ifdef SQUARE_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            error_out <= 1'b1;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          result_valid_out <= 1'b0;
`ifdef SQUARE_ARB_TIMEOUT_EN
          error_out        <= 1'b0;
`endif
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_square_arbiter.sv
// Bench for square_arbiter: schedule-based model of expected outputs per cycle,
// a behavioural square-unit stub, and directed requests with literal pins.
module tb_square_arbiter;
  localparam int N    = 4;
  localparam int T    = 15;
  localparam int MAXC = 512;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b1;
  logic [N-1:0]     req_in = '0;
  logic [8*N-1:0]   value_in = '0;
  logic [N-1:0]     grant_out;
  logic [15:0]      result_out;
  logic [1:0]       result_id_out;
  logic             result_valid_out, busy_out, error_out, sq_ready_out;
  logic [7:0]       sq_value_out;
  logic [15:0]      sq_square_in = '0;
  logic             sq_busy_in = 1'b0;
  logic             sq_valid_in = 1'b0;

  square_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in), .value_in(value_in),
    .grant_out(grant_out), .result_out(result_out), .result_id_out(result_id_out),
    .result_valid_out(result_valid_out), .busy_out(busy_out), .error_out(error_out),
    .sq_ready_out(sq_ready_out), .sq_value_out(sq_value_out),
    .sq_square_in(sq_square_in), .sq_busy_in(sq_busy_in), .sq_valid_in(sq_valid_in)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Square unit stub: result valid stub_delay cycles after the ready cycle.
  int stub_delay = 2;
  bit stub_stall = 1'b0;
  int tmr = 0;
  bit active = 1'b0;

  always @(posedge clk_in) begin
    if (rst_in) begin
      active <= 1'b0; sq_valid_in <= 1'b0; sq_busy_in <= 1'b0; sq_square_in <= '0;
    end else begin
      sq_valid_in <= 1'b0;
      if (sq_ready_out) begin
        active       <= !stub_stall;
        tmr          <= stub_delay - 1;
        sq_busy_in   <= 1'b1;
        sq_square_in <= 16'(sq_value_out) * 16'(sq_value_out);
      end else if (active) begin
        if (tmr == 1) begin
          sq_valid_in <= 1'b1; active <= 1'b0; sq_busy_in <= 1'b0;
        end else tmr <= tmr - 1;
      end
    end
  end

  // Expected outputs indexed by cycle; held outputs change only where set_* marks it.
  bit [N-1:0] e_grant [MAXC];
  bit e_rdy [MAXC], e_busy [MAXC], e_rv [MAXC], e_err [MAXC];
  bit set_id [MAXC], set_val [MAXC], set_res [MAXC];
  int v_id [MAXC], v_val [MAXC], v_res [MAXC];
  int cur_id = 0, cur_val = 0, cur_res = 0;
  int m_ptr = 0, m_free = 0, cyc = -1, start = 1 << 30;
  int w, fin, idx, opv;
  bit err;

  always @(negedge clk_in) begin
    cyc++;
    if (cyc >= start && cyc < MAXC) begin
      if (set_id[cyc])  cur_id  = v_id[cyc];
      if (set_val[cyc]) cur_val = v_val[cyc];
      if (set_res[cyc]) cur_res = v_res[cyc];
      check("grant", 32'(grant_out), 32'(e_grant[cyc]));
      check("sq_ready", 32'(sq_ready_out), 32'(e_rdy[cyc]));
      check("busy", 32'(busy_out), 32'(e_busy[cyc]));
      check("result_valid", 32'(result_valid_out), 32'(e_rv[cyc]));
      check("error", 32'(error_out), 32'(e_err[cyc]));
      check("result", 32'(result_out), cur_res);
      check("result_id", 32'(result_id_out), cur_id);
      check("sq_value", 32'(sq_value_out), cur_val);
    end
    if (rst_in) begin
      if (start > cyc + 1) start = cyc + 1;
      for (int i = cyc + 1; i < MAXC; i++) begin
        e_grant[i] = '0; e_rdy[i] = 0; e_busy[i] = 0; e_rv[i] = 0; e_err[i] = 0;
        set_id[i] = 0; set_val[i] = 0; set_res[i] = 0;
      end
      if (cyc + 1 < MAXC) begin
        set_id[cyc+1] = 1; v_id[cyc+1] = 0;
        set_val[cyc+1] = 1; v_val[cyc+1] = 0;
        set_res[cyc+1] = 1; v_res[cyc+1] = 0;
      end
      m_ptr = 0; m_free = cyc + 1;
    end else if (cyc >= m_free && req_in != '0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (w < 0 && req_in[idx]) w = idx;
      end
      opv = int'(value_in[8*w +: 8]);
      m_ptr = (w + 1) % N;
`ifdef SQUARE_ARB_TIMEOUT_EN
      err = stub_stall || (stub_delay > T);
      fin = err ? cyc + 2 + T : cyc + 2 + stub_delay;
`else
      err = 1'b0;
      fin = cyc + 2 + stub_delay;
`endif
      if (fin < MAXC) begin
        e_grant[cyc+1] = N'(1) << w;
        e_rdy[cyc+1]   = 1;
        set_id[cyc+1]  = 1; v_id[cyc+1]  = w;
        set_val[cyc+1] = 1; v_val[cyc+1] = opv;
        for (int i = cyc + 1; i <= fin; i++) e_busy[i] = 1;
        if (err) e_err[fin] = 1;
        else begin
          e_rv[fin] = 1; set_res[fin] = 1; v_res[fin] = opv * opv;
        end
      end
      m_free = fin + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  initial begin
    tick(2); rst_in = 1'b0; tick(2);

    // Single request, operand 12.
    value_in[7:0] = 8'd12; req_in = 4'b0001;
    tick(1); check("t1_grant", 32'(grant_out), 32'd1); check("t1_ready", 32'(sq_ready_out), 32'd1);
    tick(1); req_in = '0;
    tick(2); check("t1_valid", 32'(result_valid_out), 32'd1);
    check("t1_result", 32'(result_out), 32'd144); check("t1_id", 32'(result_id_out), 32'd0);
    tick(3);

    // All four continuously from a fresh pointer.
    rst_in = 1'b1; tick(1); rst_in = 1'b0; tick(1);
    value_in = {8'd4, 8'd3, 8'd2, 8'd1}; req_in = 4'b1111;
    tick(1);
    for (int k = 0; k < 5; k++) begin
      check("t2_grant", 32'(grant_out), 32'(1) << (k % 4));
      if (k == 4) begin tick(1); req_in = '0; tick(2); end
      else tick(3);
      check("t2_valid", 32'(result_valid_out), 32'd1);
      check("t2_result", 32'(result_out), 32'((k % 4 + 1) * (k % 4 + 1)));
      check("t2_id", 32'(result_id_out), 32'(k % 4));
      tick(2);
    end

    // Wrap-around: grant 3 then 1010 gives 1 then 3.
    value_in[31:24] = 8'd9; value_in[15:8] = 8'd7; req_in = 4'b1000;
    tick(1); check("t3_grant3", 32'(grant_out), 32'h8);
    tick(1); req_in = '0; tick(3);
    req_in = 4'b1010;
    tick(1); check("t3_grant1", 32'(grant_out), 32'h2);
    tick(3); check("t3_id1", 32'(result_id_out), 32'd1); check("t3_res1", 32'(result_out), 32'd49);
    tick(2); check("t3_grant3b", 32'(grant_out), 32'h8);
    tick(1); req_in = '0; tick(4);

    // Maximum operand on requester 2.
    value_in[23:16] = 8'd255; req_in = 4'b0100;
    tick(1); tick(1); req_in = '0;
    tick(2); check("t4_valid", 32'(result_valid_out), 32'd1);
    check("t4_result", 32'(result_out), 32'd65025); check("t4_id", 32'(result_id_out), 32'd2);
    tick(3);

    // Reset while in WAIT; pointer must restart at 0.
    value_in[7:0] = 8'd5; req_in = 4'b0001;
    tick(1); check("t5_grant", 32'(grant_out), 32'd1);
    tick(1); req_in = '0; check("t5_busy_wait", 32'(busy_out), 32'd1); rst_in = 1'b1;
    tick(1); rst_in = 1'b0;
    check("t5_rst_grant", 32'(grant_out), 32'd0); check("t5_rst_ready", 32'(sq_ready_out), 32'd0);
    check("t5_rst_busy", 32'(busy_out), 32'd0); check("t5_rst_valid", 32'(result_valid_out), 32'd0);
    check("t5_rst_error", 32'(error_out), 32'd0); check("t5_rst_result", 32'(result_out), 32'd0);
    check("t5_rst_id", 32'(result_id_out), 32'd0); check("t5_rst_value", 32'(sq_value_out), 32'd0);
    tick(2);
    req_in = 4'b1001;
    tick(1); check("t5_first_grant", 32'(grant_out), 32'd1);
    tick(1); req_in = '0; tick(6);

`ifdef SQUARE_ARB_TIMEOUT_EN
    // Stalled unit: error exactly T cycles after WAIT entry.
    stub_stall = 1'b1; req_in = 4'b0001;
    tick(1); tick(1); req_in = '0;
    tick(T); check("t6_error", 32'(error_out), 32'd1); check("t6_no_valid", 32'(result_valid_out), 32'd0);
    check("t6_busy", 32'(busy_out), 32'd1);
    tick(1); check("t6_idle", 32'(busy_out), 32'd0); check("t6_error_off", 32'(error_out), 32'd0);
    tick(1);
    // Valid on the timeout cycle wins.
    stub_stall = 1'b0; stub_delay = T; req_in = 4'b0001;
    tick(1); tick(1); req_in = '0;
    tick(T); check("t7_valid", 32'(result_valid_out), 32'd1); check("t7_no_error", 32'(error_out), 32'd0);
    check("t7_result", 32'(result_out), 32'd25);
    tick(3); stub_delay = 2;
`endif

    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
